cic_comp_fir_serial: RTL and testbench



---
 rtl/cic_comp_pkg.sv | 40 ++++
 rtl/cic_comp_coef_rom.sv | 14 +
 rtl/cic_comp_fir_serial.sv | 115 +++++++++++
 tb/tb_cic_comp_fir_serial.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// Shared widths, coefficient table and FSM encoding for the inverse-sinc compensation FIR.
package cic_comp_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned COEF_W = 10;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned NTAPS  = 11;
  localparam int unsigned ACC_W  = 22;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Symmetric inverse-sinc taps, unity DC gain (sum = 256); index 0 pairs with the newest sample.
  function automatic coef_t coef_lookup(input logic [IDX_W-1:0] idx);
    coef_t c;
    case (idx)
      4'd0:    c = COEF_W'(2);
      4'd1:    c = -COEF_W'(6);
      4'd2:    c = COEF_W'(12);
      4'd3:    c = -COEF_W'(24);
      4'd4:    c = COEF_W'(46);
      4'd5:    c = COEF_W'(196);
      4'd6:    c = COEF_W'(46);
      4'd7:    c = -COEF_W'(24);
      4'd8:    c = COEF_W'(12);
      4'd9:    c = -COEF_W'(6);
      4'd10:   c = COEF_W'(2);
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cic_comp_coef_rom.sv
// Combinational tap-index to coefficient lookup.
module cic_comp_coef_rom
  import cic_comp_pkg::*;
(
  input  logic        [IDX_W-1:0]  idx,
  output logic signed [COEF_W-1:0] coef_c
);

  // Pure table read; the MAC consumes it in the same cycle.
  always_comb begin
    coef_c = coef_lookup(idx);
  end

endmodule

// File: rtl/cic_comp_fir_serial.sv
// Serial-MAC inverse-sinc compensation FIR: one tap per clock, one output per accepted sample.
module cic_comp_fir_serial
  import cic_comp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid
);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-128);

  state_e                     state_q, state_d;
  logic        [IDX_W-1:0]    idx_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   dly_q [NTAPS];

  logic                       accept_c;
  logic                       mac_en_c;
  logic                       out_load_c;
  logic signed [DATA_W-1:0]   tap_c;
  logic signed [COEF_W-1:0]   coef_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [ACC_W-1:0]    rnd_sum_c;
  logic signed [ACC_W-1:0]    rnd_shr_c;
  logic signed [DATA_W-1:0]   sat_c;

  cic_comp_coef_rom u_coef_rom (
    .idx    (idx_q),
    .coef_c (coef_c)
  );

  // Select the delay-line entry for the current tap index.
  always_comb begin
    tap_c = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (idx_q == IDX_W'(k)) tap_c = dly_q[k];
    end
  end

  // Signed product, then round-half-up by 2^FRAC_W and clamp to the sample range.
  always_comb begin
    prod_c    = PROD_W'(tap_c) * PROD_W'(coef_c);
    rnd_sum_c = acc_q + RND_HALF;
    rnd_shr_c = rnd_sum_c >>> FRAC_W;
    if (rnd_shr_c > SAT_MAX)      sat_c = DATA_W'(SAT_MAX);
    else if (rnd_shr_c < SAT_MIN) sat_c = DATA_W'(SAT_MIN);
    else                          sat_c = DATA_W'(rnd_shr_c);
  end

  // Next-state and control strobes.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    mac_en_c   = 1'b0;
    out_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_d  = MAC;
        end
      end
      MAC: begin
        mac_en_c = 1'b1;
        if (idx_q == IDX_W'(NTAPS - 1)) state_d = DONE;
      end
      DONE: begin
        out_load_c = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator, tap index and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= out_load_c;
      if (out_load_c) out_data <= sat_c;
      if (accept_c) begin
        acc_q <= '0;
        idx_q <= '0;
      end else if (mac_en_c) begin
        acc_q <= acc_q + ACC_W'(prod_c);
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Sample delay line; newest sample enters at index 0 on accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) dly_q[k] <= '0;
    end else if (accept_c) begin
      for (int k = NTAPS - 1; k > 0; k--) dly_q[k] <= dly_q[k-1];
      dly_q[0] <= in_data;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir_serial.sv
// Directed bench for the serial compensation FIR: impulse, DC, saturation, handshake, reset, idle hold.
module tb_cic_comp_fir_serial;

  logic              clk;
  logic              reset;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] out_data;
  logic              out_valid;

  int errors = 0;
  int checks = 0;

  cic_comp_fir_serial dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One handshake transfer; waits for the result and checks latency, value and pulse width.
  task automatic send(input logic signed [7:0] x, input bit chk, input int exp, input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
    check({tag, "_ready"}, int'(in_ready), 1);
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, 12);
    if (chk) check({tag, "_data"}, int'(out_data), exp);
    @(negedge clk);
    check({tag, "_pulse"}, int'(out_valid), 0);
  endtask

  int imp_exp [11] = '{1, -3, 6, -12, 23, 97, 23, -12, 6, -3, 1};
  logic signed [7:0] sat_seq [11] = '{127, -128, 127, -128, 127, 127, 127, -128, 127, -128, 127};

  int acc_n, out_n, last_acc;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    reset = 1'b1;
    @(negedge clk);

    // Impulse response
    for (int i = 0; i < 11; i++)
      send((i == 0) ? 8'sd127 : 8'sd0, 1'b1, imp_exp[i], $sformatf("imp%0d", i));

    // DC +64 settles from the 11th output
    for (int i = 0; i < 20; i++)
      send(8'sd64, (i >= 10), 64, $sformatf("dc64_%0d", i));

    // DC -128 settles from the 11th output
    for (int i = 0; i < 12; i++)
      send(-8'sd128, (i >= 10), -128, $sformatf("dcm128_%0d", i));

    // Positive saturation: unclamped 187
    for (int i = 0; i < 11; i++)
      send(sat_seq[i], (i == 10), 127, $sformatf("satp%0d", i));

    // Negative saturation with the polarity-swapped sequence
    for (int i = 0; i < 11; i++)
      send((sat_seq[i] == 8'sd127) ? -8'sd128 : 8'sd127, (i == 10), -128, $sformatf("satn%0d", i));

    // Continuous in_valid: 14 accepts, 13-cycle spacing, output 13 negedges after each accept
    in_data  = 8'sd64;
    in_valid = 1'b1;
    acc_n    = 0;
    out_n    = 0;
    last_acc = -100;
    for (int t = 0; t < 260 && out_n < 14; t++) begin
      if (out_valid === 1'b1) begin
        out_n++;
        check($sformatf("hs_out_time%0d", out_n), t, last_acc + 13);
        if (out_n >= 11) check($sformatf("hs_out_data%0d", out_n), int'(out_data), 64);
      end
      if (in_ready === 1'b1) begin
        if (acc_n < 14) begin
          if (acc_n > 0) check($sformatf("hs_gap%0d", acc_n), t - last_acc, 13);
          last_acc = t;
          acc_n++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hs_accepts", acc_n, 14);
    check("hs_outputs", out_n, 14);

    // Idle hold: result stays put with no strobes
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("idle_valid%0d", i), int'(out_valid), 0);
      check($sformatf("idle_data%0d", i), int'(out_data), 64);
    end

    // Reset asserted while the MAC sits at tap index 5
    in_data  = 8'sd100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_quiet%0d", i), int'(out_valid), 0);
    end

    // Impulse after reset must start from a clean delay line
    for (int i = 0; i < 11; i++)
      send((i == 0) ? 8'sd127 : 8'sd0, 1'b1, imp_exp[i], $sformatf("imp2_%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
